// File: rtl/bellek_denetleyici.sv
// Single-port word RAM responder for the valid/ready memory bus with fixed response latency.
// Optional range checking is enabled by defining BELLEK_HATA_EN.
module bellek_denetleyici #(
  parameter int unsigned ADRES_BIT       = 10,
  parameter int unsigned GECIKME         = 2,
  parameter string       BASLANGIC_DOSYA = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_wstrb_i,
  output logic        mem_ready_o,
  output logic [31:0] mem_rdata_o,
  output logic        mesgul_o,
  output logic        hata_o
);

  localparam logic [1:0]  StBos      = 2'd0;
  localparam logic [1:0]  StBekle    = 2'd1;
  localparam logic [1:0]  StYanit    = 2'd2;
  localparam logic [7:0]  GecikmeYuk = 8'(GECIKME);
  localparam int unsigned Derinlik   = 2 ** ADRES_BIT;
  localparam logic [31:0] HataVerisi = 32'hDEAD_BEEF;

  logic [31:0] mem_q [Derinlik];

  // The RAM is never cleared by rst.
  initial begin
    for (int unsigned i = 0; i < Derinlik; i++) mem_q[i] = 32'd0;
  end

  logic [1:0]           durum_q, durum_d;
  logic [7:0]           sayac_q, sayac_d;
  logic [ADRES_BIT-1:0] idx_q, idx_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0]           wstrb_q, wstrb_d;
  logic                 ready_q, ready_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 hata_q, hata_d;

  logic                 yakala, erisim, aralik_disi;
  logic [ADRES_BIT-1:0] sec_idx;
  logic [31:0]          sec_wdata, eski, yeni;
  logic [3:0]           sec_wstrb;

  // With GECIKME=0 the access edge is the capture edge, so use the live inputs then.
  assign yakala    = (durum_q == StBos) && mem_valid_i;
  assign sec_idx   = yakala ? mem_addr_i[ADRES_BIT+1:2] : idx_q;
  assign sec_wdata = yakala ? mem_wdata_i : wdata_q;
  assign sec_wstrb = yakala ? mem_wstrb_i : wstrb_q;

`ifdef BELLEK_HATA_EN
  logic aralik_q, aralik_d, aralik_giris;
  logic unused_adres;
  assign aralik_giris = |mem_addr_i[31:ADRES_BIT+2];
  assign aralik_d     = yakala ? aralik_giris : aralik_q;
  assign aralik_disi  = aralik_d;
  assign unused_adres = ^mem_addr_i[1:0];

  always_ff @(posedge clk) begin
    if (rst) aralik_q <= 1'b0;
    else     aralik_q <= aralik_d;
  end
`else
  logic unused_adres;
  assign aralik_disi  = 1'b0;
  assign unused_adres = ^{mem_addr_i[31:ADRES_BIT+2], mem_addr_i[1:0]};
`endif

  assign eski = mem_q[sec_idx];

  always_comb begin
    yeni = eski;
    for (int k = 0; k < 4; k++) begin
      if (sec_wstrb[k]) yeni[k*8 +: 8] = sec_wdata[k*8 +: 8];
    end
  end

  always_comb begin
    durum_d = durum_q;
    sayac_d = sayac_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    unique case (durum_q)
      StBos: begin
        if (mem_valid_i) begin
          idx_d   = mem_addr_i[ADRES_BIT+1:2];
          wdata_d = mem_wdata_i;
          wstrb_d = mem_wstrb_i;
          sayac_d = GecikmeYuk;
          durum_d = (GECIKME == 0) ? StYanit : StBekle;
        end
      end
      StBekle: begin
        sayac_d = sayac_q - 8'd1;
        if (sayac_q == 8'd1) durum_d = StYanit;
      end
      StYanit: durum_d = StBos;
      default: durum_d = StBos;
    endcase
  end

  assign erisim  = (durum_d == StYanit) && (durum_q != StYanit);
  assign ready_d = erisim;
  assign hata_d  = erisim && aralik_disi;
  assign rdata_d = !erisim ? rdata_q : (aralik_disi ? HataVerisi : yeni);

  always_ff @(posedge clk) begin
    if (rst) begin
      durum_q <= StBos;
      sayac_q <= 8'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      ready_q <= 1'b0;
      rdata_q <= 32'd0;
      hata_q  <= 1'b0;
    end else begin
      durum_q <= durum_d;
      sayac_q <= sayac_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      hata_q  <= hata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && erisim && (sec_wstrb != 4'b0000) && !aralik_disi) mem_q[sec_idx] <= yeni;
  end

  assign mem_ready_o = ready_q;
  assign mem_rdata_o = rdata_q;
  assign hata_o      = hata_q;
  assign mesgul_o    = (durum_q != StBos);

endmodule

// File: tb/tb_bellek_denetleyici.sv
// Directed self-checking bench for bellek_denetleyici with default parameters (GECIKME=2).
module tb_bellek_denetleyici;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [3:0]  mem_wstrb_i;
  logic        mem_ready_o;
  logic [31:0] mem_rdata_o;
  logic        mesgul_o;
  logic        hata_o;

  int tests_run    = 0;
  int tests_failed = 0;
  int unsigned cyc = 0;

  bellek_denetleyici dut (
    .clk         (clk),
    .rst         (rst),
    .mem_valid_i (mem_valid_i),
    .mem_addr_i  (mem_addr_i),
    .mem_wdata_i (mem_wdata_i),
    .mem_wstrb_i (mem_wstrb_i),
    .mem_ready_o (mem_ready_o),
    .mem_rdata_o (mem_rdata_o),
    .mesgul_o    (mesgul_o),
    .hata_o      (hata_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic adim();
    @(posedge clk);
    #1;
  endtask

  // Drives one request and waits (bounded) for ready; gecen = edges from first sample to ready.
  task automatic istek(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s,
                       output logic [31:0] rd, output logic ht, output int gecen,
                       output int unsigned t_ready);
    mem_valid_i = 1'b1;
    mem_addr_i  = a;
    mem_wdata_i = w;
    mem_wstrb_i = s;
    gecen = 0; rd = 32'h0; ht = 1'b0; t_ready = 0;
    for (int i = 1; i <= 20; i++) begin
      adim();
      if (mem_ready_o) begin
        gecen = i; rd = mem_rdata_o; ht = hata_o; t_ready = cyc;
        break;
      end
    end
    mem_valid_i = 1'b0;
    mem_wstrb_i = 4'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_valid_i = 1'b0; mem_addr_i = 32'h0; mem_wdata_i = 32'h0; mem_wstrb_i = 4'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tests_run++;
    if (mem_ready_o !== 1'b0 || mem_rdata_o !== 32'h0 || mesgul_o !== 1'b0 || hata_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset: ready=%b rdata=%h mesgul=%b hata=%b, want 0/00000000/0/0",
               mem_ready_o, mem_rdata_o, mesgul_o, hata_o);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic ht; int g; int unsigned t;
    adim();
    istek(32'h10, 32'hA5A5_1234, 4'hF, rd, ht, g, t);
    tests_run++;
    if (g !== 3) begin
      tests_failed++; $display("FAIL write_latency: got %0d cycles, want 3", g);
    end
    tests_run++;
    if (rd !== 32'hA5A5_1234 || ht !== 1'b0) begin
      tests_failed++; $display("FAIL write_rdata: got %h hata=%b, want a5a51234 hata=0", rd, ht);
    end
    adim();
    tests_run++;
    if (mem_ready_o !== 1'b0 || mesgul_o !== 1'b0 || mem_rdata_o !== 32'hA5A5_1234) begin
      tests_failed++;
      $display("FAIL ready_pulse: ready=%b mesgul=%b rdata=%h, want 0/0/a5a51234",
               mem_ready_o, mesgul_o, mem_rdata_o);
    end
    istek(32'h10, 32'h0, 4'h0, rd, ht, g, t);
    tests_run++;
    if (rd !== 32'hA5A5_1234 || g !== 3) begin
      tests_failed++; $display("FAIL read_back: got %h in %0d, want a5a51234 in 3", rd, g);
    end
  endtask

  task automatic test_byte_strobe();
    logic [31:0] rd; logic ht; int g; int unsigned t;
    adim();
    istek(32'h10, 32'h0000_BB00, 4'b0010, rd, ht, g, t);
    tests_run++;
    if (rd !== 32'hA5A5_BB34) begin
      tests_failed++; $display("FAIL strobe_write: got %h, want a5a5bb34", rd);
    end
    adim();
    istek(32'h13, 32'hFFFF_FFFF, 4'h0, rd, ht, g, t);
    tests_run++;
    if (rd !== 32'hA5A5_BB34) begin
      tests_failed++; $display("FAIL strobe_read: got %h, want a5a5bb34", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd0, rd1; logic ht; int g; int unsigned t0, t1;
    adim();
    istek(32'h0, 32'h1111_2222, 4'hF, rd0, ht, g, t0);
    adim();
    istek(32'h4, 32'h3333_4444, 4'hF, rd1, ht, g, t1);
    adim();
    istek(32'h0, 32'h0, 4'h0, rd0, ht, g, t0);
    adim();
    istek(32'h4, 32'h0, 4'h0, rd1, ht, g, t1);
    tests_run++;
    if (rd0 !== 32'h1111_2222 || rd1 !== 32'h3333_4444) begin
      tests_failed++;
      $display("FAIL b2b_data: got %h %h, want 11112222 33334444", rd0, rd1);
    end
    tests_run++;
    if (t1 - t0 !== 4) begin
      tests_failed++; $display("FAIL b2b_spacing: got %0d cycles, want 4", t1 - t0);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic ht; int g; int unsigned t;
    bit goruldu;
    adim();
    istek(32'h20, 32'h1357_9BDF, 4'hF, rd, ht, g, t);
    adim();
    mem_valid_i = 1'b1; mem_addr_i = 32'h20; mem_wdata_i = 32'hFFFF_FFFF; mem_wstrb_i = 4'hF;
    adim();
    tests_run++;
    if (mesgul_o !== 1'b1) begin
      tests_failed++; $display("FAIL busy_in_wait: mesgul=%b, want 1", mesgul_o);
    end
    rst = 1'b1; mem_valid_i = 1'b0; mem_wstrb_i = 4'h0;
    adim();
    rst = 1'b0;
    goruldu = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (mem_ready_o) goruldu = 1'b1;
      adim();
    end
    tests_run++;
    if (goruldu || mesgul_o !== 1'b0 || mem_rdata_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_abort: ready_seen=%b mesgul=%b rdata=%h, want 0/0/00000000",
               goruldu, mesgul_o, mem_rdata_o);
    end
    istek(32'h20, 32'h0, 4'h0, rd, ht, g, t);
    tests_run++;
    if (rd !== 32'h1357_9BDF) begin
      tests_failed++; $display("FAIL reset_no_write: got %h, want 13579bdf", rd);
    end
  endtask

  task automatic test_range();
    logic [31:0] rd; logic ht; int g; int unsigned t;
    logic [31:0] bek_rd; logic bek_ht;
`ifdef BELLEK_HATA_EN
    bek_rd = 32'hDEAD_BEEF; bek_ht = 1'b1;
`else
    bek_rd = 32'h1111_2222; bek_ht = 1'b0;
`endif
    adim();
    istek(32'h0000_1000, 32'h0, 4'h0, rd, ht, g, t);
    tests_run++;
    if (rd !== bek_rd || ht !== bek_ht || g !== 3) begin
      tests_failed++;
      $display("FAIL range_read: got %h hata=%b in %0d, want %h hata=%b in 3",
               rd, ht, g, bek_rd, bek_ht);
    end
    adim();
    tests_run++;
    if (hata_o !== 1'b0) begin
      tests_failed++; $display("FAIL hata_pulse: hata=%b, want 0", hata_o);
    end
    istek(32'h0, 32'h0, 4'h0, rd, ht, g, t);
    tests_run++;
    if (rd !== 32'h1111_2222 || ht !== 1'b0) begin
      tests_failed++; $display("FAIL range_ram_intact: got %h hata=%b, want 11112222 0", rd, ht);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_strobe();
    test_back_to_back();
    test_reset_mid();
    test_range();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
